// File: rtl/vec_pkg.sv
// Shared types and sizing for the vector register file.
// The lane write-mask helper is the single point that decides which lanes a write touches.
package vec_pkg;

  localparam int NREG  = 16;
  localparam int AW    = 4;
  localparam int LANES = 6;
  localparam int LW    = 8;
  localparam int IW    = 4;

  typedef logic [LANES-1:0][LW-1:0] vec_t;
  typedef logic [AW-1:0]            reg_addr_t;
  typedef logic [LANES-1:0]         lane_mask_t;

  // A scalar load only touches lane 0; otherwise every lane is written.
  function automatic lane_mask_t lane_we_f(input logic we, input logic ld);
    lane_mask_t mask;
    mask = '0;
    if (we) begin
      mask = ld ? lane_mask_t'(1) : '1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/reg_file_vreg_entry.sv
// One 48-bit vector register with asynchronous clear and per-lane write enables.
module vreg_entry
  import vec_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  lane_mask_t i_lane_we,
  input  vec_t       i_wd,
  output vec_t       o_q
);

  vec_t r_q;

  // NOTE: storage is cleared by reset here because software expects all registers to read 0
  // after reset; a large RAM-style memory would normally be left unreset.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else begin
      for (int l = 0; l < LANES; l++) begin
        if (i_lane_we[l]) begin
          r_q[l] <= i_wd[l];
        end
      end
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/reg_file.sv
// Vector register file: 16 x (6 lanes x 8 bits), two combinational read ports,
// one synchronous write port with a lane-0-only scalar load mode.
module reg_file
  import vec_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           WE3,
  input  logic           LDFlag,
  input  reg_addr_t      A1,
  input  reg_addr_t      A2,
  input  reg_addr_t      A3,
  input  vec_t           WD3,
  output vec_t           RD1,
  output vec_t           RD2,
  output logic [IW-1:0]  RD2I
);

  lane_mask_t w_lane_we;
  vec_t       w_regs [NREG];

  assign w_lane_we = lane_we_f(WE3, LDFlag);

  for (genvar g = 0; g < NREG; g++) begin : g_entry
    lane_mask_t w_entry_we;

    assign w_entry_we = (A3 == reg_addr_t'(g)) ? w_lane_we : '0;

    vreg_entry u_entry (
      .clk       (clk),
      .rst       (rst),
      .i_lane_we (w_entry_we),
      .i_wd      (WD3),
      .o_q       (w_regs[g])
    );
  end

  // Reads come straight from storage: a same-cycle write is only visible after the edge.
  assign RD1  = w_regs[A1];
  assign RD2  = w_regs[A2];
  assign RD2I = RD2[0][IW-1:0];

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file: reset, full/scalar writes, write disable,
// read-during-write ordering, asynchronous reset and a full address sweep.
module tb_reg_file;
  import vec_pkg::*;

  logic      clk = 1'b0;
  logic      rst;
  logic      WE3;
  logic      LDFlag;
  reg_addr_t A1;
  reg_addr_t A2;
  reg_addr_t A3;
  vec_t      WD3;
  vec_t      RD1;
  vec_t      RD2;
  logic [IW-1:0] RD2I;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_file dut (
    .clk    (clk),
    .rst    (rst),
    .WE3    (WE3),
    .LDFlag (LDFlag),
    .A1     (A1),
    .A2     (A2),
    .A3     (A3),
    .WD3    (WD3),
    .RD1    (RD1),
    .RD2    (RD2),
    .RD2I   (RD2I)
  );

  task automatic check(input string tag, input logic [47:0] observed, input logic [47:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  task automatic wr(input reg_addr_t addr, input logic [47:0] data, input logic ld);
    @(negedge clk);
    WE3    = 1'b1;
    LDFlag = ld;
    A3     = addr;
    WD3    = data;
    @(posedge clk);
    #1;
    WE3    = 1'b0;
    LDFlag = 1'b0;
  endtask

  initial begin
    logic [7:0]  b;
    logic [47:0] exp_v;

    rst = 1'b1; WE3 = 1'b0; LDFlag = 1'b0;
    A1 = '0; A2 = '0; A3 = '0; WD3 = '0;

    // Reset state across every address
    #2;
    for (int i = 0; i < NREG; i++) begin
      A1 = reg_addr_t'(i);
      A2 = reg_addr_t'(i);
      #1;
      check("rst_rd1", RD1, 48'h0);
      check("rst_rd2", RD2, 48'h0);
      check("rst_rd2i", 48'(RD2I), 48'h0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Full-vector writes, narrow data zero-extended
    wr(4'd1, 48'h0000_0000_ABCD, 1'b0);
    wr(4'd2, 48'h0000_0000_1234, 1'b0);
    A1 = 4'd1; A2 = 4'd2;
    #1;
    check("wr_rd1", RD1, 48'h0000_0000_ABCD);
    check("wr_rd2", RD2, 48'h0000_0000_1234);
    check("wr_rd2i", 48'(RD2I), 48'h4);

    // Scalar load touches lane 0 only
    wr(4'd5, 48'h1122_3344_5566, 1'b0);
    wr(4'd5, 48'hFFFF_FFFF_FF99, 1'b1);
    A1 = 4'd5; A2 = 4'd5;
    #1;
    check("ld_rd1", RD1, 48'h1122_3344_5599);
    check("ld_rd2_same_addr", RD2, 48'h1122_3344_5599);
    check("ld_rd2i", 48'(RD2I), 48'h9);

    // LDFlag with WE3=0 changes nothing
    @(negedge clk);
    WE3 = 1'b0; LDFlag = 1'b1; A3 = 4'd5; WD3 = 48'hFFFF_FFFF_FF00;
    @(posedge clk);
    #1;
    LDFlag = 1'b0;
    check("ld_no_we", RD1, 48'h1122_3344_5599);

    // Write disabled leaves reg3 at zero
    @(negedge clk);
    WE3 = 1'b0; A3 = 4'd3; WD3 = 48'h0000_0000_DEAD; A1 = 4'd3;
    @(posedge clk);
    #1;
    check("we0_rd1", RD1, 48'h0);

    // Same-cycle read of the write address: old value before the edge, new after
    @(negedge clk);
    WE3 = 1'b1; LDFlag = 1'b0; A3 = 4'd3; WD3 = 48'h0000_0000_DEAD; A1 = 4'd3;
    #1;
    check("rw_pre_edge", RD1, 48'h0);
    @(posedge clk);
    #1;
    WE3 = 1'b0;
    check("rw_post_edge", RD1, 48'h0000_0000_DEAD);

    // Asynchronous reset between edges clears outputs without a clock
    @(negedge clk);
    #2;
    A1 = 4'd5; A2 = 4'd1;
    rst = 1'b1;
    #1;
    check("arst_rd1", RD1, 48'h0);
    check("arst_rd2", RD2, 48'h0);
    check("arst_rd2i", 48'(RD2I), 48'h0);
    WE3 = 1'b1; LDFlag = 1'b0; A3 = 4'd7; WD3 = 48'h0A0B_0C0D_0E0F; A1 = 4'd7;
    @(posedge clk);
    #1;
    check("arst_wr_blocked", RD1, 48'h0);
    @(negedge clk);
    WE3 = 1'b0;
    rst = 1'b0;
    #1;
    check("arst_after_release", RD1, 48'h0);
    A1 = 4'd3;
    #1;
    check("arst_reg3_cleared", RD1, 48'h0);

    // Full sweep on both ports
    for (int i = 0; i < NREG; i++) begin
      b = {4'(i), 4'(i)};
      wr(reg_addr_t'(i), {6{b}}, 1'b0);
    end
    for (int i = 0; i < NREG; i++) begin
      A1 = reg_addr_t'(i);
      A2 = reg_addr_t'(15 - i);
      #1;
      b = {4'(i), 4'(i)};
      exp_v = {6{b}};
      check("sweep_rd1", RD1, exp_v);
      b = {4'(15 - i), 4'(15 - i)};
      exp_v = {6{b}};
      check("sweep_rd2", RD2, exp_v);
      check("sweep_rd2i", 48'(RD2I), 48'(15 - i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
